// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and the
// program image format, used by the RTL and by the bench's image builder.
//
// Image format (big-endian byte stream):
//   offset 0          : word count N, high byte
//   offset 1          : word count N, low byte
//   offset 2 .. 4N+1  : N instruction words, 4 bytes each, MSB first
//   offset 4N+2       : checksum = XOR of every preceding byte
package program_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_HI = 3'd1,
        HDR_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        CSUM   = 3'd5
    } loader_state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int CSUM_BYTES = 1;

    // Total stream length in bytes for an image holding n_words words.
    function automatic int image_bytes(input int n_words);
        return HDR_BYTES + n_words * WORD_BYTES + CSUM_BYTES;
    endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Byte-to-word assembly and running checksum for the program loader.
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_clear         clears shift register, byte index and checksum (load start)
//   i_accept        a stream byte is accepted this cycle
//   i_shift_en      accepted byte is instruction data (shift into the word)
//   i_csum_en       accepted byte contributes to the running checksum
//   i_byte          stream byte
//   o_word          word including the current byte (valid with o_word_ready)
//   o_word_ready    pulse: the current accepted byte completes a word
//   o_csum          XOR of all checksum-enabled bytes accepted since clear
module loader_word_assembler
    import program_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic        i_shift_en,
    input  logic        i_csum_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_ready,
    output logic [7:0]  o_csum
);

    localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

    logic [31:0] r_shift;
    logic [1:0]  r_idx;
    logic [7:0]  r_csum;
    logic [31:0] w_word;

    assign w_word       = {r_shift[23:0], i_byte};
    assign o_word       = w_word;
    assign o_word_ready = i_accept && i_shift_en && (r_idx == LAST_IDX);
    assign o_csum       = r_csum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_idx   <= '0;
            r_csum  <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_idx   <= '0;
            r_csum  <= '0;
        end else if (i_accept) begin
            if (i_csum_en) begin
                r_csum <= r_csum ^ i_byte;
            end
            if (i_shift_en) begin
                r_shift <= w_word;
                // 2-bit index wraps to 0 after the fourth byte of a word
                r_idx   <= r_idx + 2'd1;
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a program image from a byte stream into instruction memory and holds
// the processor in reset until a load has been verified by its checksum.
//
// Ports:
//   i_clk, i_reset     clock, asynchronous active-low reset
//   i_start            one-cycle pulse, begins a load (ignored while busy)
//   i_in_valid/i_in_data, o_in_ready   byte stream handshake
//   o_mem_we/o_mem_addr/o_mem_wdata    instruction memory write port
//   o_cpu_reset        active-high processor reset
//   o_busy             load in progress
//   o_done / o_error   sticky result of the last load
//   o_words_loaded     words written in the current or last load
//
// state  | meaning
// IDLE   | waiting for start, holding result flags
// HDR_HI | receiving word count high byte
// HDR_LO | receiving word count low byte, range-checking the count
// DATA   | receiving instruction bytes
// WRITE  | one-cycle memory write of the assembled word
// CSUM   | receiving and comparing the checksum byte
module program_loader
    import program_loader_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_in_valid,
    input  logic [7:0]        i_in_data,
    output logic              o_in_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_cpu_reset,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [15:0]       o_words_loaded
);

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    loader_state_t     r_state;
    logic [15:0]       r_count;
    logic              r_in_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_cpu_reset;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic [15:0]       r_words_loaded;

    logic              w_accept;
    logic              w_clear;
    logic [31:0]       w_word;
    logic              w_word_ready;
    logic [7:0]        w_csum;
    logic [15:0]       w_new_count;

    assign w_accept    = i_in_valid && r_in_ready;
    assign w_clear     = (r_state == IDLE) && i_start;
    assign w_new_count = {r_count[15:8], i_in_data};

    loader_word_assembler u_asm (
        .i_clk        (i_clk),
        .i_rst_n      (i_reset),
        .i_clear      (w_clear),
        .i_accept     (w_accept),
        .i_shift_en   (r_state == DATA),
        .i_csum_en    (r_state != CSUM),
        .i_byte       (i_in_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready),
        .o_csum       (w_csum)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state        <= IDLE;
            r_count        <= '0;
            r_in_ready     <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_cpu_reset    <= 1'b1;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_words_loaded <= '0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state        <= HDR_HI;
                        r_in_ready     <= 1'b1;
                        r_busy         <= 1'b1;
                        r_cpu_reset    <= 1'b1;
                        r_done         <= 1'b0;
                        r_error        <= 1'b0;
                        r_words_loaded <= '0;
                        r_count        <= '0;
                    end
                end
                HDR_HI: begin
                    if (w_accept) begin
                        r_count[15:8] <= i_in_data;
                        r_state       <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (w_accept) begin
                        r_count[7:0] <= i_in_data;
                        if ({1'b0, w_new_count} > DEPTH_L) begin
                            r_state    <= IDLE;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_error    <= 1'b1;
                        end else if (w_new_count == 16'd0) begin
                            r_state <= CSUM;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_word_ready) begin
                        // Write is issued from the registers so it appears
                        // the cycle after the last byte of the word.
                        r_state        <= WRITE;
                        r_in_ready     <= 1'b0;
                        r_mem_we       <= 1'b1;
                        r_mem_addr     <= BASE_ADDR + ADDR_W'({r_words_loaded, 2'b00});
                        r_mem_wdata    <= w_word;
                        r_words_loaded <= r_words_loaded + 16'd1;
                    end
                end
                WRITE: begin
                    // r_words_loaded already includes the word being written
                    r_in_ready <= 1'b1;
                    r_state    <= (r_words_loaded == r_count) ? CSUM : DATA;
                end
                CSUM: begin
                    if (w_accept) begin
                        r_state    <= IDLE;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        if (i_in_data == w_csum) begin
                            r_done      <= 1'b1;
                            r_cpu_reset <= 1'b0;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready     = r_in_ready;
    assign o_mem_we       = r_mem_we;
    assign o_mem_addr     = r_mem_addr;
    assign o_mem_wdata    = r_mem_wdata;
    assign o_cpu_reset    = r_cpu_reset;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_error        = r_error;
    assign o_words_loaded = r_words_loaded;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: nominal, bad checksum, empty, overflow,
// backpressure with a stray start, and asynchronous reset mid-load.
module tb_program_loader;
    import program_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    program_loader dut (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .i_start        (start),
        .i_in_valid     (in_valid),
        .i_in_data      (in_data),
        .o_in_ready     (in_ready),
        .o_mem_we       (mem_we),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .o_cpu_reset    (cpu_reset),
        .o_busy         (busy),
        .o_done         (done),
        .o_error        (error),
        .o_words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Record every memory write; one entry per cycle mem_we is high.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Offer one byte; returns ok=1 when it was accepted within the budget.
    task automatic send(input logic [7:0] b, input int gap, output bit ok);
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    // Start a load and stream all but the checksum byte of an n_words image.
    task automatic load_body(input logic [7:0] img[$], input int n_words,
                             input int gap, input bit mid_start, input string tag);
        bit ok;
        int n;
        n = image_bytes(n_words);
        pulse_start();
        for (int i = 0; i < n - 1; i++) begin
            if (mid_start && i == HDR_BYTES + 2) pulse_start();
            send(img[i], gap, ok);
            chk({tag, "_accept"}, 32'(ok), 32'd1);
        end
    endtask

    task automatic check_nominal_writes(input string tag);
        chk({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            chk({tag, "_a0"}, wr_addr[0], 32'h0000_0000);
            chk({tag, "_d0"}, wr_data[0], 32'h2008_0005);
            chk({tag, "_a1"}, wr_addr[1], 32'h0000_0004);
            chk({tag, "_d1"}, wr_data[1], 32'h0000_0000);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready), 32'd0);
        chk({tag, "_mem_we"},    32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"},  mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        chk({tag, "_busy"},      32'(busy), 32'd0);
        chk({tag, "_done"},      32'(done), 32'd0);
        chk({tag, "_error"},     32'(error), 32'd0);
        chk({tag, "_words"},     32'(words_loaded), 32'd0);
    endtask

    logic [7:0] nom[$]   = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                             8'h00, 8'h00, 8'h00, 8'h00, 8'h2F};
    logic [7:0] empty[$] = '{8'h00, 8'h00, 8'h00};

    initial begin
        bit ok;

        // Power-on reset
        #12;
        check_reset_values("por");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Nominal load, with cpu_reset release timing around the checksum byte
        wr_addr.delete(); wr_data.delete();
        load_body(nom, 2, 0, 1'b0, "nom");
        chk("nom_busy_before", 32'(busy), 32'd1);
        chk("nom_cpu_rst_before", 32'(cpu_reset), 32'd1);
        send(8'h2F, 0, ok);
        chk("nom_csum_accept", 32'(ok), 32'd1);
        chk("nom_cpu_rst_after", 32'(cpu_reset), 32'd0);
        chk("nom_done", 32'(done), 32'd1);
        chk("nom_error", 32'(error), 32'd0);
        chk("nom_busy", 32'(busy), 32'd0);
        chk("nom_words", 32'(words_loaded), 32'd2);
        chk("nom_addr_hold", mem_addr, 32'h4);
        check_nominal_writes("nom");

        // Bad checksum: writes happen, error flagged, processor stays in reset
        wr_addr.delete(); wr_data.delete();
        load_body(nom, 2, 0, 1'b0, "bad");
        send(8'h30, 0, ok);
        chk("bad_csum_accept", 32'(ok), 32'd1);
        chk("bad_error", 32'(error), 32'd1);
        chk("bad_done", 32'(done), 32'd0);
        chk("bad_cpu_rst", 32'(cpu_reset), 32'd1);
        chk("bad_words", 32'(words_loaded), 32'd2);
        check_nominal_writes("bad");

        // Empty image
        wr_addr.delete(); wr_data.delete();
        load_body(empty, 0, 0, 1'b0, "emp");
        chk("emp_error_cleared", 32'(error), 32'd0);
        send(8'h00, 0, ok);
        chk("emp_csum_accept", 32'(ok), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("emp_done", 32'(done), 32'd1);
        chk("emp_cpu_rst", 32'(cpu_reset), 32'd0);
        chk("emp_words", 32'(words_loaded), 32'd0);
        chk("emp_nwr", 32'(wr_addr.size()), 32'd0);

        // Count overflow: 0x0101 = 257 > 256
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        send(8'h01, 0, ok);
        chk("ovf_hi_accept", 32'(ok), 32'd1);
        send(8'h01, 0, ok);
        chk("ovf_lo_accept", 32'(ok), 32'd1);
        chk("ovf_error", 32'(error), 32'd1);
        chk("ovf_done", 32'(done), 32'd0);
        chk("ovf_in_ready", 32'(in_ready), 32'd0);
        chk("ovf_busy", 32'(busy), 32'd0);
        chk("ovf_cpu_rst", 32'(cpu_reset), 32'd1);
        send(8'h20, 0, ok);
        chk("ovf_no_accept", 32'(ok), 32'd0);
        chk("ovf_nwr", 32'(wr_addr.size()), 32'd0);

        // Backpressure: 3-cycle gaps, stray start during the data phase
        wr_addr.delete(); wr_data.delete();
        load_body(nom, 2, 3, 1'b1, "bp");
        chk("bp_busy_before", 32'(busy), 32'd1);
        send(8'h2F, 0, ok);
        chk("bp_csum_accept", 32'(ok), 32'd1);
        chk("bp_done", 32'(done), 32'd1);
        chk("bp_error", 32'(error), 32'd0);
        chk("bp_cpu_rst", 32'(cpu_reset), 32'd0);
        chk("bp_words", 32'(words_loaded), 32'd2);
        check_nominal_writes("bp");

        // Asynchronous reset after 5 accepted bytes
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            send(nom[i], 0, ok);
            chk("rst_accept", 32'(ok), 32'd1);
        end
        chk("rst_busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        load_body(nom, 2, 0, 1'b0, "rl");
        send(8'h2F, 0, ok);
        chk("rl_csum_accept", 32'(ok), 32'd1);
        chk("rl_done", 32'(done), 32'd1);
        chk("rl_cpu_rst", 32'(cpu_reset), 32'd0);
        chk("rl_words", 32'(words_loaded), 32'd2);
        check_nominal_writes("rl");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Loads a program image from a byte stream into the single-cycle processor's instruction memory.
- Holds the processor in reset while loading; releases it only after a verified load.
- Acts as the writer side of instruction memory; the processor fetch path is the reader.
- Image format, big-endian: 16-bit word count N, then N 32-bit instruction words, then 1 XOR checksum byte.

Parameters:
- ADDR_W, 32, width of mem_addr; byte address, matches pc width.
- DEPTH, 256, instruction memory capacity in words.
- BASE_ADDR, 0, byte address of the first word written.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load.
- in_valid  input  1  in_data is valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction memory write enable.
- mem_addr  output  ADDR_W  word-aligned byte address.
- mem_wdata  output  32  instruction word to write.
- cpu_reset  output  1  active-high reset to the processor.
- busy  output  1  load in progress.
- done  output  1  sticky; last load succeeded.
- error  output  1  sticky; last load failed (count overflow or bad checksum).
- words_loaded  output  16  words written in the current or last load.

Behaviour:
- All outputs registered.
- Reset values: state IDLE; in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_reset 1, busy 0, done 0, error 0, words_loaded 0.
- States: IDLE, HDR_HI, HDR_LO, DATA, WRITE, CSUM.
- A byte is accepted on a rising edge where in_valid && in_ready.
- in_ready = 1 only in HDR_HI, HDR_LO, DATA, CSUM.
- in_valid gaps stall the FSM indefinitely; no timeout.
- IDLE: start -> HDR_HI; busy=1, cpu_reset=1, done=0, error=0, words_loaded=0; byte index, word index and checksum cleared.
- start while busy is ignored.
- Running checksum = XOR of every accepted byte, header and data, excluding the checksum byte itself.
- HDR_HI: count[15:8] <= byte -> HDR_LO.
- HDR_LO: count[7:0] <= byte. Then:
  - count > DEPTH -> IDLE, error=1, busy=0.
  - count == 0 -> CSUM.
  - otherwise -> DATA.
- DATA: shift register wdata <= {wdata[23:0], byte}; byte index 0..3. On the 4th byte -> WRITE.
- WRITE: lasts exactly one cycle; in_ready=0.
  - mem_we=1, mem_addr = BASE_ADDR + 4*word_index (ADDR_W modulo arithmetic), mem_wdata = assembled word.
  - words_loaded increments in the same cycle.
  - Next: CSUM if words_loaded+1 == count, else DATA.
- mem_we is 0 in every other state. mem_addr and mem_wdata hold their last values.
- CSUM, on an accepted byte:
  - byte == running checksum -> IDLE; done=1, cpu_reset=0 from the next cycle, busy=0.
  - mismatch -> IDLE; error=1, cpu_reset stays 1, busy=0.
- Memory already written is never rolled back on error.
- done and error are mutually exclusive and hold until the next start or reset.
- Reset asserted mid-load: immediate return to reset values, including cpu_reset=1. Partially written memory is left as is.
- Latency: mem_we rises 1 cycle after the 4th byte of a word. cpu_reset falls 1 cycle after the checksum byte is accepted.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE..CSUM);
  - HDR_BYTES=2, WORD_BYTES=4;
  - the image format description, reused by the bench's image generator.
- One natural sub-module: loader_word_assembler. It contains the byte shift register, byte index, and the running XOR checksum, and produces a word_ready pulse.
- The FSM, address counter and handshake stay in the top module.

Test Plan:
- Nominal load: start; stream 00 02 20 08 00 05 00 00 00 00 2F -> mem_we pulses twice, (addr 0x0, data 0x20080005) then (addr 0x4, data 0x00000000); done=1, error=0, words_loaded=2; cpu_reset 1 -> 0 one cycle after 2F is accepted.
- Bad checksum: same stream ending in 30 -> both writes still occur; error=1, done=0, cpu_reset remains 1.
- Empty image: 00 00 00 -> no mem_we; done=1, words_loaded=0, cpu_reset=0.
- Overflow, DEPTH=256: 01 01 -> error=1 right after the 2nd header byte; in_ready=0; no mem_we; later bytes are not accepted.
- Backpressure: nominal stream with in_valid deasserted for 3 cycles between every byte, plus start pulsed mid-load -> identical writes and final flags; the extra start has no effect.
- Reset mid-load: drop reset after 5 accepted bytes -> all outputs return to reset values asynchronously, cpu_reset=1. Release reset, then start + nominal stream -> done=1, writes at 0x0 and 0x4.
